// File: rtl/demux_rr_sched.sv
// Round-robin burst scheduler driving the select lines of a 1:4 demux.
// One valid/ready input stream is shared across four channels in bursts of
// BURST words, skipping disabled channels and stalling on backpressure.
module demux_rr_sched #(
  parameter int unsigned DW    = 1,
  parameter int unsigned BURST = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    en_mask,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [3:0]    out_ready,
  output logic          s1,
  output logic          s0,
  output logic          busy,
  output logic          burst_done
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             burst_done_q, burst_done_d;
  logic             xfer;
  logic             last_word;

  // First enabled channel scanning start, start+1, start+2, start+3 (mod 4);
  // falls back to start when nothing is enabled.
  function automatic logic [1:0] first_enabled(input logic [1:0] start,
                                                input logic [3:0] mask);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + k[1:0];
      if (mask[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign out_data   = in_data;
  assign s1         = sel_q[1];
  assign s0         = sel_q[0];
  assign burst_done = burst_done_q;
  assign last_word  = (cnt_q == CNT_W'(BURST - 1));

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    burst_done_d = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 4'b0000;
    busy         = 1'b0;
    xfer         = 1'b0;
    case (state_q)
      StIdle: begin
        if (en_mask != 4'b0000) begin
          state_d = StSend;
          sel_d   = first_enabled(sel_q, en_mask);
          cnt_d   = '0;
        end
      end
      StSend: begin
        busy             = 1'b1;
        in_ready         = out_ready[sel_q] & en_mask[sel_q];
        out_valid[sel_q] = in_valid & en_mask[sel_q];
        xfer             = in_valid & out_ready[sel_q] & en_mask[sel_q];
        if (en_mask == 4'b0000) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!en_mask[sel_q]) begin
          // Channel dropped mid-burst: abandon it silently.
          sel_d = first_enabled(sel_q + 2'd1, en_mask);
          cnt_d = '0;
        end else if (xfer) begin
          if (last_word) begin
            cnt_d        = '0;
            sel_d        = first_enabled(sel_q + 2'd1, en_mask);
            burst_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sel_q        <= 2'b00;
      cnt_q        <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      burst_done_q <= burst_done_d;
    end
  end

endmodule

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
- Scheduler and controller for the 1:4 demultiplexer datapath.
- Accepts one valid/ready input stream and drives the demux select lines (s1, s0).
- Shares the stream among four destination channels in round-robin bursts of BURST words, honouring per-channel enable and backpressure.
- Sits directly in front of the demux; its s1/s0 connect to the demux selects, and its out_data feeds the demux data input i.

Parameters:
- DW, 1: data width in bits.
- BURST, 4: transfers sent to one channel before rotating. Legal range 1..255.
- CNT_W, 8: burst counter width. Must satisfy 2^CNT_W >= BURST.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en_mask  in  4  channel enable; bit n enables channel n.
- in_valid  in  1  input word available.
- in_data  in  DW  input word.
- in_ready  out  1  input word accepted this cycle.
- out_valid  out  4  one-hot valid to the selected channel.
- out_data  out  DW  word to the demux input (broadcast).
- out_ready  in  4  per-channel ready.
- s1  out  1  demux select MSB (sel[1]).
- s0  out  1  demux select LSB (sel[0]).
- busy  out  1  high while in SEND.
- burst_done  out  1  registered one-cycle pulse after a full burst completes.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst). Reset has priority over all other activity.
- Reset state: state=IDLE, sel=2'b00, cnt=0, burst_done=0. Consequently in_ready=0, out_valid=4'b0000, busy=0, s1=s0=0.
- out_data = in_data at all times (combinational).
- State IDLE:
  - If en_mask==0, stay in IDLE.
  - Otherwise go to SEND, and load sel with the first enabled channel searching sel, sel+1, sel+2, sel+3 (mod 4). cnt=0.
- State SEND, combinational outputs:
  - in_ready = out_ready[sel] & en_mask[sel].
  - out_valid[sel] = in_valid & en_mask[sel]; all other bits 0.
  - busy=1.
- Transfer definition: a transfer occurs when in_valid & in_ready. Routing has zero-cycle latency, with no data buffering inside the block.
- On a transfer with cnt < BURST-1: cnt increments and sel holds.
- On a transfer with cnt == BURST-1:
  - cnt=0.
  - sel advances to the next enabled channel searching sel+1, sel+2, sel+3, sel (wrap 3->0). If sel is the only enabled channel, it stays on sel.
  - burst_done=1 on the following cycle only.
- Disable mid-burst: if en_mask[sel]==0 in SEND (so no transfer is possible), abandon the burst on that edge. cnt=0, and sel advances to the next enabled channel using the search above. burst_done is NOT pulsed.
- en_mask==0 in SEND: go to IDLE; sel holds; cnt=0.
- Backpressure: in_valid=1 with out_ready[sel]=0 holds sel and cnt indefinitely. There is no timeout and no skip.
- Select timing: the new s1/s0 are valid from the cycle after the final transfer of a burst. The select never changes in a cycle with no transfer, except for the disable/abandon cases above.
- Simultaneous burst end and en_mask change: the search uses en_mask as sampled on that edge.
- Reset mid-burst: the in-flight burst is discarded with no pulse, and the block returns to the reset state.
- Count width: cnt never exceeds BURST-1. For BURST=1, every transfer rotates.

Test Plan:
- Reset case: rst=1 for 2 cycles with in_valid=1, en_mask=4'hF -> in_ready=0, out_valid=0, s1s0=00, busy=0, burst_done=0.
- Full rotation: en_mask=4'hF, out_ready=4'hF, in_valid=1 for 16 cycles -> 4 words each to channels 0,1,2,3 in order. s1s0 is 00,01,10,11 for 4 cycles each. burst_done pulses 4 times, on cycles 5, 9, 13 and 17 counted from the first transfer, then the select wraps to 00.
- Sparse mask: en_mask=4'b1010 -> only channels 1 and 3 are served, alternating every 4 words. out_valid[0] and out_valid[2] never assert.
- Backpressure: out_ready[1]=0 for 5 cycles after 2 words sent on channel 1 -> in_ready=0, cnt stays 2, s1s0 stays 01. After release, 2 more words, then rotation to channel 2.
- Disable mid-burst: clear en_mask[2] after 1 word on channel 2 -> next cycle s1s0=11, cnt=0, no burst_done. en_mask then 0 -> IDLE, busy=0.
- BURST=1 variant: en_mask=4'hF, continuous traffic -> select changes every transfer (00,01,10,11,00) and burst_done pulses every cycle after the first.
